// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the pipeline DM stage and the data-memory controller.
// The master drives requests; the slave (the controller) returns responses and status.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_err;
    logic              busy_clr;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy_clr
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy_clr
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Big-endian byte/half/word data memory with post-reset hardware clear, error reporting
// and a fixed READ_LAT request-to-response pipeline.
module dmem_ctrl #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    dmem_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = ADDR_W - 2;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t        state_reg;
    logic [AW-1:0] clr_cnt_reg;
    logic          ready_reg;
    logic          busy_reg;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_raw_reg;

    logic          s0_valid_reg;
    logic [1:0]    s0_err_reg;
    logic [1:0]    s0_lane_reg;
    logic [1:0]    s0_size_reg;
    logic          s0_sgn_reg;
    logic          s0_ld_ok_reg;

    logic          accept;
    logic [IW-1:0] word_idx;
    logic [1:0]    lane;
    logic [AW-1:0] mem_idx;
    logic          misal;
    logic          out_of_range;
    logic          wr_en;
    logic          clr_we;
    logic [3:0]    wr_be;
    logic [3:0][7:0] wr_word;

    assign accept       = bus.req_valid & ready_reg;
    assign word_idx     = bus.req_addr[ADDR_W-1:2];
    assign lane         = bus.req_addr[1:0];
    assign mem_idx      = word_idx[AW-1:0];
    assign out_of_range = |(word_idx >> AW);
    assign wr_en        = accept & bus.req_we & ~misal & ~out_of_range;
    assign clr_we       = (state_reg == CLEAR) & rst;

    always_comb begin
        misal = 1'b1;
        unique case (bus.req_size)
            2'b00:   misal = 1'b0;
            2'b01:   misal = lane[0];
            2'b10:   misal = |lane;
            default: misal = 1'b1;
        endcase
    end

    // Lane 0 is the most significant byte, so lane gi lives in byte 3-gi of the word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        localparam int         BIT  = 8 * (3 - gi);
        assign wr_be[3-gi] = wr_en & (((bus.req_size == 2'b00) && (lane == LANE)) ||
                                      ((bus.req_size == 2'b01) && (lane[1] == LANE[1])) ||
                                       (bus.req_size == 2'b10));
        assign wr_word[3-gi] = (bus.req_size == 2'b10) ? bus.req_wdata[BIT +: 8] :
                               (bus.req_size == 2'b01) ? (LANE[0] ? bus.req_wdata[7:0]
                                                                  : bus.req_wdata[15:8]) :
                               bus.req_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_reg] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= wr_word[i];
                end
            end
        end
        if (accept) begin
            rd_raw_reg <= mem[mem_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
        end else begin
            unique case (state_reg)
                CLEAR: begin
                    if (clr_cnt_reg == AW'(DEPTH - 1)) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request attributes travel alongside the RAM read register; they only load on accept
    // so the response data holds its last value between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid_reg <= 1'b0;
            s0_err_reg   <= '0;
            s0_lane_reg  <= '0;
            s0_size_reg  <= '0;
            s0_sgn_reg   <= 1'b0;
            s0_ld_ok_reg <= 1'b0;
        end else begin
            s0_valid_reg <= accept;
            if (accept) begin
                s0_err_reg   <= {out_of_range, misal};
                s0_lane_reg  <= lane;
                s0_size_reg  <= bus.req_size;
                s0_sgn_reg   <= bus.req_signed;
                s0_ld_ok_reg <= ~bus.req_we & ~misal & ~out_of_range;
            end
        end
    end

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_data;

    assign rd_byte = rd_raw_reg[{~s0_lane_reg, 3'b000} +: 8];
    assign rd_half = s0_lane_reg[1] ? rd_raw_reg[15:0] : rd_raw_reg[31:16];

    always_comb begin
        ext_data = '0;
        if (s0_ld_ok_reg) begin
            unique case (s0_size_reg)
                2'b00:   ext_data = {{24{s0_sgn_reg & rd_byte[7]}}, rd_byte};
                2'b01:   ext_data = {{16{s0_sgn_reg & rd_half[15]}}, rd_half};
                default: ext_data = rd_raw_reg;
            endcase
        end
    end

    logic        out_valid;
    logic [1:0]  out_err;
    logic [31:0] out_data;

    if (READ_LAT == 1) begin : g_direct
        assign out_valid = s0_valid_reg;
        assign out_err   = s0_err_reg;
        assign out_data  = ext_data;
    end else begin : g_pipe
        localparam int N = READ_LAT - 1;
        logic [N-1:0] pv_reg;
        logic [1:0]   pe_reg [N];
        logic [31:0]  pd_reg [N];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pv_reg <= '0;
                for (int i = 0; i < N; i++) begin
                    pe_reg[i] <= '0;
                    pd_reg[i] <= '0;
                end
            end else begin
                pv_reg[0] <= s0_valid_reg;
                if (s0_valid_reg) begin
                    pe_reg[0] <= s0_err_reg;
                    pd_reg[0] <= ext_data;
                end
                for (int i = 1; i < N; i++) begin
                    pv_reg[i] <= pv_reg[i-1];
                    if (pv_reg[i-1]) begin
                        pe_reg[i] <= pe_reg[i-1];
                        pd_reg[i] <= pd_reg[i-1];
                    end
                end
            end
        end

        assign out_valid = pv_reg[N-1];
        assign out_err   = pe_reg[N-1];
        assign out_data  = pd_reg[N-1];
    end

    assign bus.req_ready = ready_reg;
    assign bus.busy_clr  = busy_reg;
    assign bus.rsp_valid = out_valid;
    assign bus.rsp_err   = out_valid ? out_err : 2'b00;
    assign bus.rsp_rdata = out_data;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized scoreboard bench for dmem_ctrl against a byte-addressed big-endian model.
module tb_dmem_ctrl;
    localparam int DEPTH    = 256;
    localparam int ADDR_W   = 11;
    localparam int READ_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [1:0]  err;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [4*DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          txn_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    // Issue one request at the next negedge; the model computes the expected response.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int unsigned a;
        logic        misal;
        logic        oor;
        int          n;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 4*DEPTH) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        a     = 32'(addr);
        misal = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
        oor   = (a >= 4*DEPTH);
        e.id   = txn_id++;
        e.err  = {oor, misal};
        e.data = 32'h0;
        e.due  = cyc + READ_LAT;
        if (!misal && !oor) begin
            if (we) begin
                case (size)
                    2'b00: ref_mem[a] = wdata[7:0];
                    2'b01: begin
                        ref_mem[a]   = wdata[15:8];
                        ref_mem[a+1] = wdata[7:0];
                    end
                    default: begin
                        ref_mem[a]   = wdata[31:24];
                        ref_mem[a+1] = wdata[23:16];
                        ref_mem[a+2] = wdata[15:8];
                        ref_mem[a+3] = wdata[7:0];
                    end
                endcase
            end else begin
                case (size)
                    2'b00: e.data = {{24{sgn & ref_mem[a][7]}}, ref_mem[a]};
                    2'b01: e.data = {{16{sgn & ref_mem[a][7]}}, ref_mem[a], ref_mem[a+1]};
                    default: e.data = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
                endcase
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_busy_clr", 32'(bus.busy_clr), 32'd1);
    endtask

    // One-cycle reset pulse; anything in flight is dropped from the scoreboard.
    task automatic pulse_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        bus.req_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_vals();
        #1 rst = 1'b1;
        clear_model();
    endtask

    task automatic wait_clear();
        int   n;
        logic ready_seen;
        n = 0;
        ready_seen = 1'b0;
        while (bus.busy_clr && n < 4*DEPTH) begin
            if (bus.req_ready) ready_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("clear_len", 32'(n), 32'(DEPTH));
        chk("ready_during_clear", 32'(ready_seen), 32'd0);
        chk("ready_after_clear", 32'(bus.req_ready), 32'd1);
    endtask

    // Monitor: every response is popped against the scoreboard, including its arrival cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", bus.rsp_rdata, e.data);
                        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                        chk("rsp_cycle", 32'(cyc), 32'(e.due));
                        $display("rsp #%0d data=%h err=%b cycle=%0d", e.id, bus.rsp_rdata,
                                 bus.rsp_err, cyc);
                    end
                end else begin
                    chk("idle_err", 32'(bus.rsp_err), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        int                r;
        int                n;

        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        clear_model();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        #1 rst = 1'b1;
        wait_clear();

        // Directed: extension, lane placement, errors, aliasing of out-of-range stores
        issue(1'b0, 2'b10, 1'b0, 11'h3FC, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 11'h010, 32'h8899AABB);
        issue(1'b0, 2'b00, 1'b1, 11'h011, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 11'h011, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 11'h012, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 11'h010, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 11'h013, 32'h0000007F);
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 11'h010, 32'h00001234);
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 11'h001, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 11'h006, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 11'h004, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 11'h020, 32'h0);
        issue(1'b1, 2'b11, 1'b0, 11'h020, 32'hFFFFFFFF);
        issue(1'b0, 2'b10, 1'b0, 11'h020, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 11'h400, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 11'h410, 32'hCAFEF00D);
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 11'h7FF, 32'h0);
        idle(2);

        // Pipelining: six back-to-back loads of distinct words, then store/load same word
        for (int i = 0; i < 6; i++) issue(1'b1, 2'b10, 1'b0, 11'(32'h40 + 4*i), $urandom);
        idle(1);
        for (int i = 0; i < 6; i++) issue(1'b0, 2'b10, 1'b0, 11'(32'h40 + 4*i), 32'h0);
        issue(1'b1, 2'b10, 1'b0, 11'h060, 32'h13579BDF);
        issue(1'b0, 2'b10, 1'b0, 11'h060, 32'h0);
        idle(2);

        // Random mix with occasional gaps
        for (int i = 0; i < 400; i++) begin
            r    = $urandom_range(0, 15);
            size = (r == 15) ? 2'b11 : 2'(r % 3);
            addr = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(0, 2047))
                                                : ADDR_W'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'b01) addr[0] = 1'b0;
                if (size == 2'b10) addr[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(READ_LAT + 2);

        // Reset with three loads in flight, then again mid-clear; memory must come back zeroed
        issue(1'b1, 2'b10, 1'b0, 11'h080, 32'hA5A5A5A5);
        issue(1'b0, 2'b10, 1'b0, 11'h080, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 11'h040, 32'h0);
        pulse_reset();
        repeat (60) @(negedge clk);
        chk("busy_mid_clear", 32'(bus.busy_clr), 32'd1);
        pulse_reset();
        wait_clear();
        issue(1'b0, 2'b10, 1'b0, 11'h080, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 11'h010, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 11'h041, 32'h0);
        idle(1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
